// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
package uart_pkg;

  // Register selector, taken from dir[3:2]
  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;

  // STATUS bit positions
  localparam int ST_LLENA    = 0;
  localparam int ST_VACIA    = 1;
  localparam int ST_OCUPADO  = 2;
  localparam int ST_DESBORDE = 3;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    INICIO = 2'd1,
    DATOS  = 2'd2,
    PARADA = 2'd3
  } estado_t;

  // A programmed divisor of 0 would give a zero-length bit; treat it as 1.
  function automatic logic [15:0] div_efectivo(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/fifo_sinc.sv
// Single-clock FIFO; count is one bit wider than the pointers so full is distinct from empty.
module fifo_sinc #(
  parameter int ANCHO     = 8,
  parameter int PROF_LOG2 = 3
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic [ANCHO-1:0]     i_dato_in,
  output logic [ANCHO-1:0]     o_dato_out,
  output logic                 o_llena,
  output logic                 o_vacia,
  output logic [PROF_LOG2:0]   o_cuenta
);

  localparam int PROF = 1 << PROF_LOG2;

  logic [ANCHO-1:0]     r_mem [PROF];
  logic [PROF_LOG2-1:0] r_wr;
  logic [PROF_LOG2-1:0] r_rd;
  logic [PROF_LOG2:0]   r_cuenta;
  logic                 w_push_ok;
  logic                 w_pop_ok;

  // Full/empty come from the registered count, so a same-cycle pop never frees room for a push.
  assign o_llena    = (r_cuenta == (PROF_LOG2+1)'(PROF));
  assign o_vacia    = (r_cuenta == '0);
  assign o_cuenta   = r_cuenta;
  assign o_dato_out = r_mem[r_rd];
  assign w_push_ok  = i_push & ~o_llena;
  assign w_pop_ok   = i_pop & ~o_vacia;

  // Storage array; contents need no reset since the count gates every read.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr] <= i_dato_in;
  end

  // Pointers wrap naturally; count moves only when exactly one side is active.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_cuenta <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + PROF_LOG2'(1);
      if (w_pop_ok)  r_rd <= r_rd + PROF_LOG2'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_cuenta <= r_cuenta + (PROF_LOG2+1)'(1);
        2'b01:   r_cuenta <= r_cuenta - (PROF_LOG2+1)'(1);
        default: r_cuenta <= r_cuenta;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: address decode, registers, FIFO and serialiser FSM.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] DIR_BASE  = 32'h0000_1000,
  parameter logic [15:0] DIVISOR   = 16'd434,
  parameter int          PROF_LOG2 = 3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_dir,
  input  logic [31:0] i_dat_escritura,
  input  logic        i_hab_escritura,
  output logic        o_sel,
  output logic [31:0] o_dat_lectura,
  output logic        o_tx
);

  logic [1:0]         w_reg;
  logic               w_wr;
  logic               w_push;
  logic               w_pop;
  logic               w_llena;
  logic               w_vacia;
  logic [PROF_LOG2:0] w_cuenta;
  logic [7:0]         w_dato;
  logic [15:0]        w_recarga;

  logic [15:0] r_div;
  logic        r_desborde;
  estado_t     r_estado;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_tx;

  assign o_sel     = (i_dir[31:4] == DIR_BASE[31:4]);
  assign w_reg     = i_dir[3:2];
  assign w_wr      = o_sel & i_hab_escritura;
  assign w_push    = w_wr & (w_reg == REG_DATA);
  assign w_pop     = (r_estado == REPOSO) & ~w_vacia;
  // Reload value sampled only at bit entry, so divisor writes land on bit boundaries.
  assign w_recarga = div_efectivo(r_div) - 16'd1;
  assign o_tx      = r_tx;

  fifo_sinc #(.ANCHO(8), .PROF_LOG2(PROF_LOG2)) u_fifo (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_dato_in  (i_dat_escritura[7:0]),
    .o_dato_out (w_dato),
    .o_llena    (w_llena),
    .o_vacia    (w_vacia),
    .o_cuenta   (w_cuenta)
  );

  // Divisor register and sticky overflow flag (write-1-to-clear).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div      <= DIVISOR;
      r_desborde <= 1'b0;
    end else begin
      if (w_wr && w_reg == REG_DIVISOR) r_div <= i_dat_escritura[15:0];
      if (w_push && w_llena)
        r_desborde <= 1'b1;
      else if (w_wr && w_reg == REG_STATUS && i_dat_escritura[ST_DESBORDE])
        r_desborde <= 1'b0;
    end
  end

  // Serialiser: start bit, 8 data bits LSB first, stop bit, each div_efectivo cycles long.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_estado <= REPOSO;
      r_tx     <= 1'b1;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
    end else begin
      case (r_estado)
        REPOSO: begin
          if (!w_vacia) begin
            r_shift  <= w_dato;
            r_tx     <= 1'b0;
            r_cnt    <= w_recarga;
            r_estado <= INICIO;
          end
        end
        INICIO: begin
          if (r_cnt == '0) begin
            r_tx     <= r_shift[0];
            r_shift  <= {1'b0, r_shift[7:1]};
            r_bit    <= '0;
            r_cnt    <= w_recarga;
            r_estado <= DATOS;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        DATOS: begin
          if (r_cnt == '0) begin
            r_cnt <= w_recarga;
            if (r_bit == 3'd7) begin
              r_tx     <= 1'b1;
              r_estado <= PARADA;
            end else begin
              r_tx    <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
              r_bit   <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        PARADA: begin
          if (r_cnt == '0) r_estado <= REPOSO;
          else             r_cnt    <= r_cnt - 16'd1;
        end
        default: r_estado <= REPOSO;
      endcase
    end
  end

  // Combinational read mux; zero whenever this block is not addressed.
  always_comb begin
    o_dat_lectura = '0;
    if (o_sel) begin
      case (w_reg)
        REG_STATUS: begin
          o_dat_lectura[ST_LLENA]    = w_llena;
          o_dat_lectura[ST_VACIA]    = w_vacia;
          o_dat_lectura[ST_OCUPADO]  = (r_estado != REPOSO);
          o_dat_lectura[ST_DESBORDE] = r_desborde;
          o_dat_lectura[7:4]         = 4'(w_cuenta);
        end
        REG_DIVISOR: o_dat_lectura[15:0] = r_div;
        default:     o_dat_lectura = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomized bench for uart_tx_mmio against a frame-level queue model.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic [31:0] dir = BASE;
  logic [31:0] dat = '0;
  logic        sel;
  logic [31:0] rd;
  logic        tx;

  always #5 clk = ~clk;

  uart_tx_mmio dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_dir           (dir),
    .i_dat_escritura (dat),
    .i_hab_escritura (we),
    .o_sel           (sel),
    .o_dat_lectura   (rd),
    .o_tx            (tx)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Model: a byte queue plus the frame in flight as a list of 10 line levels.
  byte unsigned m_q[$];
  bit  m_des  = 0;
  bit  m_busy = 0;
  bit  m_tx   = 1;
  int  m_div  = 434;
  bit  m_bits[10];
  int  m_idx  = 0;
  int  m_left = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] v;
    int n;
    v = '0;
    n = m_q.size();
    if (a[31:4] != BASE[31:4]) return '0;
    case (a[3:2])
      2'd1: begin
        v[0]   = (n == 8);
        v[1]   = (n == 0);
        v[2]   = m_busy;
        v[3]   = m_des;
        v[7:4] = 4'(n);
      end
      2'd2: v[15:0] = 16'(m_div);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs presented for that edge.
  task automatic model_step();
    int eff, n;
    bit wr;
    byte unsigned b;
    if (rst) begin
      m_q.delete();
      m_des = 0; m_div = 434; m_busy = 0; m_tx = 1;
      return;
    end
    eff = (m_div == 0) ? 1 : m_div;
    n   = m_q.size();
    wr  = (dir[31:4] == BASE[31:4]) && we;
    if (m_busy) begin
      if (m_left == 0) begin
        m_idx++;
        if (m_idx == 10) begin
          m_busy = 0;
          m_tx   = 1;
        end else begin
          m_tx   = m_bits[m_idx];
          m_left = eff - 1;
        end
      end else begin
        m_left--;
      end
    end else if (n > 0) begin
      b = m_q.pop_front();
      m_bits[0] = 0;
      for (int i = 0; i < 8; i++) m_bits[i+1] = b[i];
      m_bits[9] = 1;
      m_idx = 0; m_left = eff - 1; m_busy = 1; m_tx = 0;
    end
    if (wr) begin
      case (dir[3:2])
        2'd0: if (n < 8) m_q.push_back(dat[7:0]); else m_des = 1;
        2'd1: if (dat[3]) m_des = 0;
        2'd2: m_div = int'(dat[15:0]);
        default: ;
      endcase
    end
  endtask

  // One bus cycle: drive at negedge, check outputs against the model, then step on posedge.
  task automatic cyc(input logic r, input logic [31:0] a, input logic [31:0] d, input logic w,
                     input int etx = -1, input logic [31:0] erd = 32'hFFFF_FFFF);
    @(negedge clk);
    rst = r; dir = a; dat = d; we = w;
    #1;
    if (chk_en) begin
      chk("sel", {31'b0, sel}, {31'b0, (a[31:4] == BASE[31:4])});
      chk("rdata", rd, m_read(a));
      chk("tx", {31'b0, tx}, {31'b0, m_tx});
      if (etx >= 0) chk("tx_directed", {31'b0, tx}, 32'(etx));
      if (erd != 32'hFFFF_FFFF) chk("rd_directed", rd, erd);
    end
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, BASE + 32'd4, 0, 0);
  endtask

  logic [9:0] fr;
  int e;
  int r;
  logic [31:0] a;

  initial begin
    // Reset and initial state
    cyc(1, BASE, 0, 0);
    cyc(1, BASE, 0, 0);
    chk_en = 1;
    cyc(0, BASE + 32'd4, 0, 0, 1, 32'h0000_0002);
    cyc(0, BASE + 32'd8, 0, 0, 1, 32'd434);

    // Decode: one block above is not ours, reserved reads zero
    cyc(0, BASE + 32'h10, 32'hA5, 1);
    cyc(0, BASE + 32'h4, 0, 0, 1, 32'h0000_0002);
    cyc(0, BASE + 32'hC, 0, 0, 1, 32'h0);

    // Single frame at divisor 4
    cyc(0, BASE + 32'd8, 32'd4, 1);
    cyc(0, BASE, 32'h55, 1);
    fr = {1'b1, 8'h55, 1'b0};
    for (int j = 0; j < 43; j++) begin
      e = (j == 0 || j > 40) ? 1 : int'(fr[(j-1)/4]);
      cyc(0, BASE + 32'd4, 0, 0, e);
    end

    // Divisor 0 behaves as 1
    cyc(0, BASE + 32'd8, 32'd0, 1);
    cyc(0, BASE, 32'hC3, 1);
    idle(15);

    // Divisor changed mid-bit keeps the current bit's length
    cyc(0, BASE + 32'd8, 32'd6, 1);
    cyc(0, BASE, 32'hF0, 1);
    idle(3);
    cyc(0, BASE + 32'd8, 32'd2, 1);
    idle(40);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 99);
      a = BASE + {28'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if (r < 15)
        cyc(0, {BASE[31:4], 2'd0, 2'($urandom)}, $urandom, 1);
      else if (r < 20)
        cyc(0, {BASE[31:4], 2'd2, 2'($urandom)}, {16'($urandom), 16'($urandom_range(0, 5))}, 1);
      else if (r < 23)
        cyc(0, {BASE[31:4], 2'd1, 2'($urandom)}, $urandom, 1);
      else if (r < 26)
        cyc(0, $urandom, $urandom, 1);
      else if (r < 28)
        cyc(0, {BASE[31:4], 2'd3, 2'($urandom)}, $urandom, 1);
      else if (r < 29)
        cyc(1, a, $urandom, $urandom_range(0, 1));
      else
        cyc(0, a, $urandom, 0);
    end

    // Fill and overflow at the reset divisor
    cyc(1, BASE, 0, 0);
    for (int j = 0; j < 10; j++) cyc(0, BASE, 32'(8'h10 + j), 1);
    cyc(0, BASE + 32'd4, 0, 0, 0, 32'h0000_008D);
    cyc(0, BASE + 32'd4, 32'h8, 1);
    cyc(0, BASE + 32'd4, 0, 0, 0, 32'h0000_0085);

    // Reset while shifting data bits: line returns high, queue discarded
    idle(600);
    cyc(1, BASE + 32'd4, 0, 0);
    cyc(0, BASE + 32'd4, 0, 0, 1, 32'h0000_0002);
    for (int j = 0; j < 300; j++) cyc(0, BASE + 32'd4, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
